// File: rtl/iob_gpio_stim_seq.sv
// Timed GPIO stimulus sequencer: queued {delay, value, mask} events are replayed
// onto gpio_out over an iob register interface, with optional looping and readback.
module iob_gpio_stim_seq #(
  parameter int GPIO_W  = 32,
  parameter int DEPTH   = 16,
  parameter int DELAY_W = 16,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        wstrb,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              busy,
  output logic              done
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = DELAY_W + 2 * GPIO_W;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, APPLY} state_t;

  state_t              state_q, state_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [GPIO_W-1:0]   gpio_out_q, gpio_out_d;
  logic                done_q, done_d;
  logic                loop_q, loop_d;
  logic                run_loop_q, run_loop_d;
  logic                overflow_q, overflow_d;
  logic [31:0]         evt_cnt_q, evt_cnt_d;
  logic [DELAY_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]       play_ptr_q, play_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       len_q, len_d;
  logic [CW-1:0]       idx_q, idx_d;
  logic [DELAY_W-1:0]  stg_delay_q, stg_delay_d;
  logic [GPIO_W-1:0]   stg_value_q, stg_value_d;
  logic [GPIO_W-1:0]   cur_value_q, cur_value_d;
  logic [GPIO_W-1:0]   cur_mask_q, cur_mask_d;
  logic [GPIO_W-1:0]   sync1_q, sync2_q;

  logic [EW-1:0]       mem [DEPTH];
  logic [EW-1:0]       mem_rd;
  logic [DELAY_W-1:0]  ent_delay;
  logic [GPIO_W-1:0]   ent_value, ent_mask;

  logic acc, wr, rd, ctrl_wr, start, stop, clear, push_req, push_ok, pop;

  assign mem_rd = mem[play_ptr_q];
  assign {ent_delay, ent_value, ent_mask} = mem_rd;

  always_comb begin
    acc      = valid && !ready_q;
    wr       = acc && (wstrb != 4'd0);
    rd       = acc && (wstrb == 4'd0);
    ctrl_wr  = wr && (address == ADDR_W'(0));
    start    = ctrl_wr && wdata[0];
    stop     = ctrl_wr && wdata[1];
    clear    = ctrl_wr && wdata[2];
    push_req = wr && (address == ADDR_W'(4));

    state_d     = state_q;
    ready_d     = acc;
    rdata_d     = '0;
    gpio_out_d  = gpio_out_q;
    done_d      = 1'b0;
    loop_d      = loop_q;
    run_loop_d  = run_loop_q;
    overflow_d  = overflow_q;
    evt_cnt_d   = evt_cnt_q;
    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    play_ptr_d  = play_ptr_q;
    count_d     = count_q;
    len_d       = len_q;
    idx_d       = idx_q;
    stg_delay_d = stg_delay_q;
    stg_value_d = stg_value_q;
    cur_value_d = cur_value_q;
    cur_mask_d  = cur_mask_q;
    pop         = 1'b0;
    push_ok     = 1'b0;

    if (ctrl_wr) loop_d = wdata[3];
    if (wr && (address == ADDR_W'(2))) stg_delay_d = wdata[DELAY_W-1:0];
    if (wr && (address == ADDR_W'(3))) stg_value_d = wdata[GPIO_W-1:0];

    if (rd) begin
      case (address)
        ADDR_W'(1): rdata_d = DATA_W'({8'(count_q), 4'd0, overflow_q, (count_q == '0),
                                       (count_q == CW'(DEPTH)), (state_q != IDLE)});
        ADDR_W'(5): rdata_d = DATA_W'(gpio_out_q);
        ADDR_W'(6): rdata_d = evt_cnt_q;
        ADDR_W'(7): rdata_d = DATA_W'(sync2_q);
        default:    rdata_d = '0;
      endcase
    end

    if (clear) begin
      state_d    = IDLE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      evt_cnt_d  = '0;
    end else begin
      if (stop) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE: if (start && (count_q != '0)) begin
            state_d    = LOAD;
            evt_cnt_d  = '0;
            play_ptr_d = rd_ptr_q;
            idx_d      = '0;
            len_d      = count_q;
            run_loop_d = loop_d;
          end
          LOAD: begin
            cnt_d       = ent_delay;
            cur_value_d = ent_value;
            cur_mask_d  = ent_mask;
            state_d     = WAIT;
          end
          WAIT: if (cnt_q == '0) state_d = APPLY;
                else cnt_d = cnt_q - DELAY_W'(1);
          APPLY: begin
            gpio_out_d = (gpio_out_q & ~cur_mask_q) | (cur_value_q & cur_mask_q);
            if (evt_cnt_q != 32'hFFFF_FFFF) evt_cnt_d = evt_cnt_q + 32'd1;
            state_d = LOAD;
            // Looping replays only the entries that were queued when the run began.
            if (run_loop_q) begin
              if (idx_q + CW'(1) == len_q) begin
                play_ptr_d = rd_ptr_q;
                idx_d      = '0;
              end else begin
                play_ptr_d = play_ptr_q + PW'(1);
                idx_d      = idx_q + CW'(1);
              end
            end else begin
              pop        = 1'b1;
              play_ptr_d = play_ptr_q + PW'(1);
            end
          end
          default: state_d = IDLE;
        endcase
      end

      push_ok = push_req && ((count_q != CW'(DEPTH)) || pop);
      if (push_req && !push_ok) overflow_d = 1'b1;
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop);
      if (pop && (count_d == '0)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= {stg_delay_q, stg_value_q, wdata[GPIO_W-1:0]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      gpio_out_q  <= '0;
      done_q      <= 1'b0;
      loop_q      <= 1'b0;
      run_loop_q  <= 1'b0;
      overflow_q  <= 1'b0;
      evt_cnt_q   <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      play_ptr_q  <= '0;
      count_q     <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      stg_delay_q <= '0;
      stg_value_q <= '0;
      cur_value_q <= '0;
      cur_mask_q  <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      gpio_out_q  <= gpio_out_d;
      done_q      <= done_d;
      loop_q      <= loop_d;
      run_loop_q  <= run_loop_d;
      overflow_q  <= overflow_d;
      evt_cnt_q   <= evt_cnt_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      play_ptr_q  <= play_ptr_d;
      count_q     <= count_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      stg_delay_q <= stg_delay_d;
      stg_value_q <= stg_value_d;
      cur_value_q <= cur_value_d;
      cur_mask_q  <= cur_mask_d;
      sync1_q     <= gpio_in;
      sync2_q     <= sync1_q;
    end
  end

  assign rdata    = rdata_q;
  assign ready    = ready_q;
  assign gpio_out = gpio_out_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
endmodule

// File: tb/tb_iob_gpio_stim_seq.sv
// Directed bench for iob_gpio_stim_seq: register reads go through an expected-value
// queue, and output timing is checked cycle by cycle against the event spacing.
module tb_iob_gpio_stim_seq;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [2:0]  address = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] rdata;
  logic        ready;
  logic [31:0] gpio_in = '0;
  logic [31:0] gpio_out;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  iob_gpio_stim_seq dut (
    .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata), .ready(ready), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
    $display("[TB] %-14s obs=0x%08h exp=0x%08h", tag, obs, exp);
  endtask

  task automatic iob_write(input logic [2:0] a, input logic [31:0] d);
    address = a; wdata = d; wstrb = 4'hF; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; wstrb = 4'h0;
    @(posedge clk); #1;
  endtask

  task automatic iob_read(input logic [2:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    exp_q.push_back(exp);
    address = a; wstrb = 4'h0; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    check({tag, "_rdy"}, 32'(ready), 32'd1);
    e = exp_q.pop_front();
    check(tag, rdata, e);
    @(posedge clk); #1;
  endtask

  task automatic push_evt(input logic [31:0] dly, input logic [31:0] val, input logic [31:0] msk);
    iob_write(3'd2, dly);
    iob_write(3'd3, val);
    iob_write(3'd4, msk);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200 && busy; i++) begin
      @(posedge clk); #1;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    check("rst_gpio", gpio_out, 32'd0);
    check("rst_flags", {28'd0, ready, busy, done, 1'b0}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    iob_read(3'd1, 32'h0000_0004, "rst_status");

    // Single event, delay 5: value appears 8 edges after the start is sampled.
    push_evt(32'd5, 32'h3, 32'hF);
    iob_read(3'd1, 32'h0000_0100, "push_status");
    iob_write(3'd0, 32'h1);
    repeat (6) @(posedge clk);
    #1 check("t_pre_apply", gpio_out, 32'h0);
    @(posedge clk); #1;
    check("t_apply", gpio_out, 32'h3);
    check("t_done", 32'(done), 32'd1);
    check("t_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("t_done_drop", 32'(done), 32'd0);
    iob_read(3'd1, 32'h0000_0004, "t_status");
    iob_read(3'd6, 32'd1, "t_evtcnt");
    iob_read(3'd5, 32'h3, "t_gpioreg");

    // Masked update keeps the unmasked bits.
    push_evt(32'd0, 32'hFF, 32'hFF);
    iob_write(3'd0, 32'h1);
    wait_idle("m_idle1");
    check("m_ff", gpio_out, 32'hFF);
    push_evt(32'd0, 32'h00, 32'h0F);
    iob_write(3'd0, 32'h1);
    wait_idle("m_idle2");
    check("m_f0", gpio_out, 32'hF0);
    iob_read(3'd5, 32'hF0, "m_gpioreg");

    // Input sampler has two cycles of latency.
    gpio_in = 32'h5A5A_0001;
    repeat (3) @(posedge clk);
    #1 iob_read(3'd7, 32'h5A5A_0001, "sample");

    // Valid held through the ready cycle is a single access.
    address = 3'd4; wdata = 32'h1; wstrb = 4'hF; valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("hold_rdy_drop", 32'(ready), 32'd0);
    valid = 1'b0; wstrb = 4'h0;
    @(posedge clk); #1;
    iob_read(3'd1, 32'h0000_0100, "hold_count");

    // Stop beats start; clear beats both; start on empty is ignored.
    iob_write(3'd0, 32'h3);
    iob_read(3'd1, 32'h0000_0100, "prec_stop");
    iob_write(3'd0, 32'h7);
    iob_read(3'd1, 32'h0000_0004, "prec_clear");
    iob_write(3'd0, 32'h1);
    iob_read(3'd1, 32'h0000_0004, "start_empty");

    // Loop: two events toggling bit0 every 5 cycles.
    push_evt(32'd2, 32'h1, 32'h1);
    iob_write(3'd3, 32'h0);
    iob_write(3'd4, 32'h1);
    iob_write(3'd0, 32'h9);
    repeat (4) @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      #1 check($sformatf("loop_ev%0d", k), gpio_out, (k % 2 == 1) ? 32'hF1 : 32'hF0);
      if (k < 10) repeat (5) @(posedge clk);
    end
    iob_write(3'd0, 32'h2);
    check("loop_busy", 32'(busy), 32'd0);
    iob_read(3'd6, 32'd10, "loop_evtcnt");
    iob_read(3'd1, 32'h0000_0200, "loop_status");
    iob_read(3'd5, 32'hF0, "loop_gpio");
    iob_write(3'd0, 32'h4);
    iob_read(3'd1, 32'h0000_0004, "clr_status");
    iob_read(3'd6, 32'd0, "clr_evtcnt");

    // Overflow: DEPTH+1 pushes.
    for (int i = 0; i <= DEPTH; i++) iob_write(3'd4, 32'h1);
    iob_read(3'd1, 32'h0000_100A, "ovf_status");
    iob_write(3'd0, 32'h4);
    iob_read(3'd1, 32'h0000_0004, "ovf_clear");

    // Asynchronous reset while waiting out a long delay.
    push_evt(32'd20, 32'hAB, 32'hFF);
    iob_write(3'd0, 32'h1);
    check("ar_busy_pre", 32'(busy), 32'd1);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("ar_gpio", gpio_out, 32'h0);
    check("ar_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    iob_read(3'd1, 32'h0000_0004, "ar_status");
    iob_read(3'd5, 32'h0, "ar_gpioreg");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
